pipe_ctrl: RTL



---
 rtl/pipe_ctrl_pkg.sv | 42 ++++
 rtl/pipe_ctrl_sat_counter.sv | 33 +++
 rtl/pipe_ctrl.sv | 136 +++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: state encodings and enable/flush bundles shared by the stall/flush sequencer.
`default_nettype none
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_MDU_WAIT = 2'd2
  } state_e;

  // Bit order: pc, if_id, id_ex, ex_mem, mem_wb
  typedef struct packed {
    logic pc;
    logic if_id;
    logic id_ex;
    logic ex_mem;
    logic mem_wb;
  } we_t;

  typedef struct packed {
    logic if_id;
    logic id_ex;
    logic ex_mem;
  } flush_t;

  localparam we_t WE_NONE  = 5'b00000;
  localparam we_t WE_ALL   = 5'b11111;
  localparam we_t WE_DRAIN = 5'b00011;  // front held, EX/MEM gets a bubble, older work retires
  localparam we_t WE_BUBBL = 5'b00111;  // front held, ID/EX gets a bubble

  function automatic logic is_load_use(
    input logic       mem_read,
    input logic [7:0] rd,
    input logic [7:0] rs,
    input logic [7:0] rt,
    input logic       uses_rt
  );
    return mem_read && (rd != 8'd0) && ((rd == rs) || (uses_rt && (rd == rt)));
  endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_ctrl_sat_counter.sv
// sat_counter: free-running event counter that sticks at all-ones instead of wrapping.
`default_nettype none
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {WIDTH{1'b1}})) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule
`default_nettype wire

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: 5-stage pipeline stall/flush sequencer (load-use, branch redirect, MDU occupancy,
// data-memory wait states) with saturating stall/flush performance counters.
`default_nettype none
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int REGADDR_WIDTH = 4,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     id_ex_mem_read,
  input  logic [REGADDR_WIDTH-1:0] id_ex_rd,
  input  logic [REGADDR_WIDTH-1:0] if_id_rs,
  input  logic [REGADDR_WIDTH-1:0] if_id_rt,
  input  logic                     if_id_uses_rt,
  input  logic                     ex_branch_taken,
  input  logic                     ex_mdu_start,
  input  logic                     mdu_done,
  input  logic                     mem_req,
  input  logic                     mem_ready,
  output logic                     pc_we,
  output logic                     if_id_we,
  output logic                     id_ex_we,
  output logic                     ex_mem_we,
  output logic                     mem_wb_we,
  output logic                     if_id_flush,
  output logic                     id_ex_flush,
  output logic                     ex_mem_flush,
  output logic [CNT_WIDTH-1:0]     stall_cnt,
  output logic [CNT_WIDTH-1:0]     flush_cnt,
  output logic                     busy
);

  state_e state_q, state_d;
  logic   done_pend_q, done_pend_d;
  logic   load_use, mem_stall, branch_evt;
  we_t    we;
  flush_t fl;

  assign load_use  = is_load_use(id_ex_mem_read, 8'(id_ex_rd), 8'(if_id_rs), 8'(if_id_rt),
                                 if_id_uses_rt);
  assign mem_stall = mem_req && !mem_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RUN;
      done_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      done_pend_q <= done_pend_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    done_pend_d = done_pend_q;
    case (state_q)
      ST_MDU_WAIT: begin
        if (mem_stall) begin
          // A completion seen while frozen must survive until the freeze lifts.
          if (mdu_done) done_pend_d = 1'b1;
        end else if (mdu_done || done_pend_q) begin
          state_d     = ST_RUN;
          done_pend_d = 1'b0;
        end
      end
      default: begin
        if (mem_stall)         state_d = ST_MEM_WAIT;
        else if (ex_mdu_start) state_d = ST_MDU_WAIT;
        else                   state_d = ST_RUN;
      end
    endcase
  end

  always_comb begin
    we         = WE_NONE;
    fl         = '0;
    branch_evt = 1'b0;
    if (!rst && !mem_stall) begin
      case (state_q)
        ST_MDU_WAIT: begin
          if (mdu_done || done_pend_q) begin
            we = WE_ALL;
          end else begin
            we        = WE_DRAIN;
            fl.ex_mem = 1'b1;
          end
        end
        default: begin
          if (ex_mdu_start) begin
            we        = WE_DRAIN;
            fl.ex_mem = 1'b1;
          end else if (ex_branch_taken) begin
            // Any load-use now belongs to a wrong-path instruction being squashed.
            we         = WE_ALL;
            fl.if_id   = 1'b1;
            fl.id_ex   = 1'b1;
            branch_evt = 1'b1;
          end else if (load_use) begin
            we       = WE_BUBBL;
            fl.id_ex = 1'b1;
          end else begin
            we = WE_ALL;
          end
        end
      endcase
    end
  end

  assign pc_we        = we.pc;
  assign if_id_we     = we.if_id;
  assign id_ex_we     = we.id_ex;
  assign ex_mem_we    = we.ex_mem;
  assign mem_wb_we    = we.mem_wb;
  assign if_id_flush  = fl.if_id;
  assign id_ex_flush  = fl.id_ex;
  assign ex_mem_flush = fl.ex_mem;
  assign busy         = !rst && (state_q != ST_RUN);

  sat_counter #(.WIDTH(CNT_WIDTH)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (!rst && !we.pc),
    .count (stall_cnt)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (branch_evt),
    .count (flush_cnt)
  );

endmodule
`default_nettype wire
